serial_adder_subtractor: RTL and testbench



---
 rtl/serial_adder_subtractor.sv | 96 +++++++++
 tb/tb_serial_adder_subtractor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_subtractor.sv
// Bit-serial LSB-first adder/subtractor: one full-adder slice plus a carry flop,
// WIDTH clocks per operation, results held in output registers until the next completion.
module serial_adder_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;
  localparam int         CNT_W   = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_ws;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;
  logic             r_done;

  logic             w_s;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_ws_next;

  assign w_s       = r_a[0] ^ r_b[0] ^ r_c;
  assign w_cout    = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_ws_next = {w_s, r_ws[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_ws    <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Subtract is A + ~B + 1: invert B on load and seed the carry with mode
            r_a     <= A;
            r_b     <= B ^ {WIDTH{mode}};
            r_c     <= mode;
            r_cnt   <= '0;
            r_ws    <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_c   <= w_cout;
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_ws  <= w_ws_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            // r_c here is the carry into the MSB, so overflow needs no extra flop
            r_sum   <= w_ws_next;
            r_carry <= w_cout;
            r_ovf   <= w_cout ^ r_c;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state == S_SHIFT);
  assign done     = r_done;
  assign sum      = r_sum;
  assign carry    = r_carry;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Directed and random checks of serial_adder_subtractor at WIDTH=4 and WIDTH=16.
module tb_serial_adder_subtractor;

  logic        clk;
  logic        rst_n;
  logic        st4, m4, busy4, done4, c4, o4;
  logic [3:0]  a4, b4, sum4;
  logic        st16, m16, busy16, done16, c16, o16;
  logic [15:0] a16, b16, sum16;

  int checks;
  int failures;

  serial_adder_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .A(a4), .B(b4), .mode(m4),
    .busy(busy4), .done(done4), .sum(sum4), .carry(c4), .overflow(o4)
  );

  serial_adder_subtractor #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .A(a16), .B(b16), .mode(m16),
    .busy(busy16), .done(done16), .sum(sum16), .carry(c16), .overflow(o16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [31:0] a, input logic [31:0] b,
                       input logic m);
    if (w == 4) begin
      st4 = st; a4 = a[3:0]; b4 = b[3:0]; m4 = m;
    end else begin
      st16 = st; a16 = a[15:0]; b16 = b[15:0]; m16 = m;
    end
  endtask

  task automatic rd(input int w, output logic [31:0] s, output logic [31:0] c,
                    output logic [31:0] o, output logic [31:0] bz, output logic [31:0] dn);
    if (w == 4) begin
      s = 32'(sum4); c = 32'(c4); o = 32'(o4); bz = 32'(busy4); dn = 32'(done4);
    end else begin
      s = 32'(sum16); c = 32'(c16); o = 32'(o16); bz = 32'(busy16); dn = 32'(done16);
    end
  endtask

  // Reference: parallel add of A and (B ^ mode) with carry-in mode, flags from sign bits
  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b, input logic m,
                       output logic [31:0] s, output logic [31:0] c, output logic [31:0] o);
    logic [33:0] mask, aa, bb, full;
    mask = (34'd1 << w) - 34'd1;
    aa   = {2'b0, a} & mask;
    bb   = m ? (~{2'b0, b} & mask) : ({2'b0, b} & mask);
    full = aa + bb + 34'(m);
    s = 32'(full & mask);
    c = 32'(full[w]);
    o = 32'((aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]));
  endtask

  task automatic check_res(input int w, input logic [31:0] es, input logic [31:0] ec,
                           input logic [31:0] eo, input string tag);
    logic [31:0] s, c, o, bz, dn;
    rd(w, s, c, o, bz, dn);
    chk({tag, "_sum"}, s, es);
    chk({tag, "_carry"}, c, ec);
    chk({tag, "_ovf"}, o, eo);
  endtask

  // Called at the negedge after the accepting edge; returns at the done cycle
  task automatic wait_done(input int w, input string tag);
    logic [31:0] s, c, o, bz, dn;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      rd(w, s, c, o, bz, dn);
      if ((bz[0] & dn[0]) == 1'b1) chk({tag, "_busy_done_overlap"}, bz & dn, 32'd0);
    end while (dn[0] !== 1'b1 && n <= w + 4);
    chk({tag, "_latency"}, 32'(n), 32'(w));
  endtask

  task automatic op(input int w, input logic [31:0] a, input logic [31:0] b, input logic m,
                    input string tag);
    logic [31:0] s, c, o, bz, dn, es, ec, eo;
    drive(w, 1'b1, a, b, m);
    @(negedge clk);
    drive(w, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ~m);
    rd(w, s, c, o, bz, dn);
    chk({tag, "_busy"}, bz, 32'd1);
    wait_done(w, tag);
    model(w, a, b, m, es, ec, eo);
    check_res(w, es, ec, eo, tag);
  endtask

  initial begin
    logic [31:0] s, c, o, bz, dn, ra, rb, mask;
    logic rm;
    int n;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    drive(4, 1'b0, 0, 0, 1'b0);
    drive(16, 1'b0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    rd(4, s, c, o, bz, dn);
    chk("rst_busy", bz, 0); chk("rst_done", dn, 0);
    chk("rst_sum", s, 0); chk("rst_carry", c, 0); chk("rst_ovf", o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-computed results
    op(4, 3, 4, 1'b0, "add_3_4");           check_res(4, 4'b0111, 0, 0, "hand_add");
    @(negedge clk);
    op(4, 7, 1, 1'b0, "add_ovf");           check_res(4, 4'b1000, 0, 1, "hand_add_ovf");
    @(negedge clk);
    op(4, 5, 3, 1'b1, "sub_5_3");           check_res(4, 4'b0010, 1, 0, "hand_sub");
    @(negedge clk);
    op(4, 3, 5, 1'b1, "sub_3_5");           check_res(4, 4'b1110, 0, 0, "hand_sub_neg");
    @(negedge clk);
    op(4, 4'b1000, 4'b0001, 1'b1, "sub_ovf"); check_res(4, 4'b0111, 1, 1, "hand_sub_ovf");

    // Outputs hold between operations
    repeat (5) @(negedge clk);
    check_res(4, 4'b0111, 1, 1, "hold");
    rd(4, s, c, o, bz, dn);
    chk("hold_done_low", dn, 0);

    // Second start during SHIFT is ignored
    drive(4, 1'b1, 5, 3, 1'b1);
    @(negedge clk);
    drive(4, 1'b0, 0, 0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) drive(4, 1'b1, 1, 1, 1'b0);
      else drive(4, 1'b0, 0, 0, 1'b0);
      rd(4, s, c, o, bz, dn);
    end while (dn[0] !== 1'b1 && n <= 8);
    chk("ignore_latency", 32'(n), 4);
    check_res(4, 4'b0010, 1, 0, "ignore_res");
    @(negedge clk);
    rd(4, s, c, o, bz, dn);
    chk("ignore_no_restart", bz, 0);
    chk("ignore_done_pulse", dn, 0);

    // Back-to-back: new start on the done cycle
    op(4, 3, 4, 1'b0, "b2b_first");
    op(4, 7, 1, 1'b0, "b2b_second");
    check_res(4, 4'b1000, 0, 1, "b2b_hand");

    // Asynchronous reset two cycles into an operation
    @(negedge clk);
    drive(4, 1'b1, 5, 3, 1'b1);
    @(negedge clk);
    drive(4, 1'b0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    rd(4, s, c, o, bz, dn);
    chk("arst_busy", bz, 0); chk("arst_done", dn, 0);
    chk("arst_sum", s, 0); chk("arst_carry", c, 0); chk("arst_ovf", o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      rd(4, s, c, o, bz, dn);
      if (dn[0] === 1'b1 || bz[0] === 1'b1) n++;
    end
    chk("arst_no_done_after", 32'(n), 0);
    check_res(4, 0, 0, 0, "arst_out_after");

    // Random operands at both widths, with occasional idle gaps
    for (int w = 4; w <= 16; w += 12) begin
      mask = (w == 4) ? 32'hF : 32'hFFFF;
      for (int i = 0; i < 500; i++) begin
        ra = $urandom & mask;
        rb = $urandom & mask;
        rm = 1'($urandom_range(0, 1));
        op(w, ra, rb, rm, (w == 4) ? "rand4" : "rand16");
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
